// File: rtl/e203_exu_alu_share_arb.sv
// rtl/e203_exu_alu_share_arb.sv - shares one ALU adder/comparator between the BJP (r0) and ALU (r1) requesters
module e203_exu_alu_share_arb #(
  parameter int XLEN       = 32,
  parameter int OPW        = 7,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            r0_req_valid,
  output logic            r0_req_ready,
  input  logic [XLEN-1:0] r0_req_op1,
  input  logic [XLEN-1:0] r0_req_op2,
  input  logic [OPW-1:0]  r0_req_op,
  output logic            r0_rsp_valid,
  input  logic            r0_rsp_ready,
  output logic [XLEN-1:0] r0_rsp_res,
  output logic            r0_rsp_cmp,
  input  logic            r1_req_valid,
  output logic            r1_req_ready,
  input  logic [XLEN-1:0] r1_req_op1,
  input  logic [XLEN-1:0] r1_req_op2,
  input  logic [OPW-1:0]  r1_req_op,
  output logic            r1_rsp_valid,
  input  logic            r1_rsp_ready,
  output logic [XLEN-1:0] r1_rsp_res,
  output logic            r1_rsp_cmp,
  output logic [XLEN-1:0] dp_op1,
  output logic [XLEN-1:0] dp_op2,
  output logic [OPW-1:0]  dp_op,
  input  logic [XLEN-1:0] dp_add_res,
  input  logic            dp_cmp_res
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t          state_q, state_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            owner_q, owner_d, cmp_q, cmp_d;
  logic [3:0]      starve_q, starve_d;
  logic            rsp_hs, can_issue, pick_r1, grant0, grant1;

  always_comb begin
    rsp_hs    = (state_q == RESP) && (owner_q ? r1_rsp_ready : r0_rsp_ready);
    // a new grant may overlap the response handshake so back-to-back ops see no bubble
    can_issue = !rst && !flush && ((state_q == IDLE) || rsp_hs);
    pick_r1   = r1_req_valid && (!r0_req_valid || (starve_q == STARVE_LIM));
    grant1    = can_issue && pick_r1;
    grant0    = can_issue && r0_req_valid && !pick_r1;
  end

  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op_d     = op_q;
    owner_d  = owner_q;
    res_d    = res_q;
    cmp_d    = cmp_q;
    starve_d = starve_q;

    if (grant0) begin
      op1_d   = r0_req_op1;
      op2_d   = r0_req_op2;
      op_d    = r0_req_op;
      owner_d = 1'b0;
      if (!r1_req_valid) begin
        starve_d = 4'd0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (grant1) begin
      op1_d    = r1_req_op1;
      op2_d    = r1_req_op2;
      op_d     = r1_req_op;
      owner_d  = 1'b1;
      starve_d = 4'd0;
    end

    unique case (state_q)
      IDLE: if (grant0 || grant1) state_d = EXEC;
      EXEC: begin
        res_d   = dp_add_res;
        cmp_d   = dp_cmp_res;
        state_d = RESP;
      end
      RESP: if (rsp_hs) state_d = (grant0 || grant1) ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase

    // flush abandons the in-flight op but keeps the fairness history
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      op_q     <= '0;
      owner_q  <= 1'b0;
      res_q    <= '0;
      cmp_q    <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op_q     <= op_d;
      owner_q  <= owner_d;
      res_q    <= res_d;
      cmp_q    <= cmp_d;
      starve_q <= starve_d;
    end
  end

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;
  assign r0_rsp_valid = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid = (state_q == RESP) && owner_q;
  assign r0_rsp_res   = res_q;
  assign r1_rsp_res   = res_q;
  assign r0_rsp_cmp   = cmp_q;
  assign r1_rsp_cmp   = cmp_q;
  assign dp_op1       = op1_q;
  assign dp_op2       = op2_q;
  assign dp_op        = (state_q == EXEC) ? op_q : '0;

endmodule

// File: tb/tb_e203_exu_alu_share_arb.sv
// tb/tb_e203_exu_alu_share_arb.sv - scoreboard bench for the shared ALU arbiter
module tb_e203_exu_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_cmp;
  logic [31:0] r0_req_op1, r0_req_op2, r0_rsp_res;
  logic [6:0]  r0_req_op;
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_cmp;
  logic [31:0] r1_req_op1, r1_req_op2, r1_rsp_res;
  logic [6:0]  r1_req_op;
  logic [31:0] dp_op1, dp_op2, dp_add_res;
  logic [6:0]  dp_op;
  logic        dp_cmp_res;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        cmp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;

  e203_exu_alu_share_arb #(.XLEN(32), .OPW(7), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_op1(r0_req_op1), .r0_req_op2(r0_req_op2), .r0_req_op(r0_req_op),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_res(r0_rsp_res), .r0_rsp_cmp(r0_rsp_cmp),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_op1(r1_req_op1), .r1_req_op2(r1_req_op2), .r1_req_op(r1_req_op),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_res(r1_rsp_res), .r1_rsp_cmp(r1_rsp_cmp),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_op(dp_op),
    .dp_add_res(dp_add_res), .dp_cmp_res(dp_cmp_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared adder/comparator
  always_comb begin
    dp_add_res = dp_op1 + dp_op2;
    dp_cmp_res = (dp_op[1] && (dp_op1 == dp_op2)) ||
                 (dp_op[2] && (dp_op1 != dp_op2)) ||
                 (dp_op[3] && ($signed(dp_op1) < $signed(dp_op2))) ||
                 (dp_op[4] && ($signed(dp_op1) > $signed(dp_op2))) ||
                 (dp_op[5] && (dp_op1 < dp_op2)) ||
                 (dp_op[6] && (dp_op1 > dp_op2));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic owner, input logic [31:0] res, input logic cmp);
    exp_t e;
    e.owner = owner;
    e.res   = res;
    e.cmp   = cmp;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic owner, input logic [31:0] res, input logic cmp);
    exp_t e;
    if (sb.size() == 0) begin
      check("rsp_unexpected", {63'd0, owner}, 64'hdead);
    end else begin
      e = sb.pop_front();
      check("rsp_owner", {63'd0, owner}, {63'd0, e.owner});
      check("rsp_res", {32'd0, res}, {32'd0, e.res});
      check("rsp_cmp", {63'd0, cmp}, {63'd0, e.cmp});
    end
  endtask

  // monitor: every completed response handshake is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (r0_rsp_valid && r1_rsp_valid) check("both_rsp_valid", 64'd1, 64'd0);
      if (r0_rsp_valid && r0_rsp_ready) pop_cmp(1'b0, r0_rsp_res, r0_rsp_cmp);
      if (r1_rsp_valid && r1_rsp_ready) pop_cmp(1'b1, r1_rsp_res, r1_rsp_cmp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic order [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int grants, last, guard;
    rst = 1'b1; flush = 1'b0;
    r0_req_valid = 1'b0; r0_req_op1 = '0; r0_req_op2 = '0; r0_req_op = '0; r0_rsp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_req_op1 = '0; r1_req_op2 = '0; r1_req_op = '0; r1_rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    @(negedge clk);
    check("rst_dp_op1", {32'd0, dp_op1}, 64'd0);
    check("rst_dp_op", {57'd0, dp_op}, 64'd0);
    check("rst_r0_rsp_valid", {63'd0, r0_rsp_valid}, 64'd0);
    check("rst_r1_rsp_valid", {63'd0, r1_rsp_valid}, 64'd0);
    check("rst_r0_rsp_res", {32'd0, r0_rsp_res}, 64'd0);

    // lone r0 add
    step();
    r0_req_valid = 1'b1; r0_req_op1 = 32'h8000_0000; r0_req_op2 = 32'd4; r0_req_op = 7'h01;
    @(negedge clk);
    check("t1_r0_ready_c0", {63'd0, r0_req_ready}, 64'd1);
    check("t1_r1_ready_c0", {63'd0, r1_req_ready}, 64'd0);
    push_exp(1'b0, 32'h8000_0004, 1'b0);
    step();
    r0_req_valid = 1'b0;
    @(negedge clk);
    check("t1_dp_op_c1", {57'd0, dp_op}, 64'h01);
    check("t1_dp_op1_c1", {32'd0, dp_op1}, 64'h8000_0000);
    check("t1_rsp_valid_c1", {63'd0, r0_rsp_valid}, 64'd0);
    step();
    @(negedge clk);
    check("t1_r0_rsp_valid_c2", {63'd0, r0_rsp_valid}, 64'd1);
    check("t1_r1_rsp_valid_c2", {63'd0, r1_rsp_valid}, 64'd0);
    check("t1_dp_op_c2", {57'd0, dp_op}, 64'h00);
    repeat (2) step();

    // starvation guard: both valid continuously
    for (int i = 0; i < 8; i++) push_exp(order[i], order[i] ? 32'd4 : 32'd2, 1'b0);
    r0_req_valid = 1'b1; r0_req_op1 = 32'd1; r0_req_op2 = 32'd1; r0_req_op = 7'h01;
    r1_req_valid = 1'b1; r1_req_op1 = 32'd2; r1_req_op2 = 32'd2; r1_req_op = 7'h01;
    grants = 0; last = -1; guard = 0;
    while (grants < 8 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (r0_req_ready || r1_req_ready) begin
        check("t2_grant_owner", {63'd0, r1_req_ready}, {63'd0, order[grants]});
        if (last >= 0) check("t2_grant_gap", 64'(cyc - last), 64'd2);
        last = cyc;
        grants++;
      end
      step();
    end
    check("t2_grant_count", 64'(grants), 64'd8);
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    repeat (4) step();

    // r1 cmp_ltu with a stalled response, r0 waiting behind it
    r1_rsp_ready = 1'b0;
    r1_req_valid = 1'b1; r1_req_op1 = 32'd1; r1_req_op2 = 32'hFFFF_FFFF; r1_req_op = 7'h20;
    @(negedge clk);
    check("t3_r1_ready", {63'd0, r1_req_ready}, 64'd1);
    push_exp(1'b1, 32'd0, 1'b1);
    step();
    r1_req_valid = 1'b0;
    r0_req_valid = 1'b1; r0_req_op1 = 32'd3; r0_req_op2 = 32'd4; r0_req_op = 7'h01;
    @(negedge clk);
    check("t3_r0_blocked_exec", {63'd0, r0_req_ready}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("t3_hold_valid", {63'd0, r1_rsp_valid}, 64'd1);
      check("t3_hold_cmp", {63'd0, r1_rsp_cmp}, 64'd1);
      check("t3_r0_blocked_resp", {63'd0, r0_req_ready}, 64'd0);
    end
    step();
    r1_rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_r0_grant_on_hs", {63'd0, r0_req_ready}, 64'd1);
    push_exp(1'b0, 32'd7, 1'b0);
    step();
    r0_req_valid = 1'b0;
    repeat (4) step();

    // flush in the EXEC cycle of an r0 op
    r0_req_valid = 1'b1; r0_req_op1 = 32'd10; r0_req_op2 = 32'd20; r0_req_op = 7'h01;
    @(negedge clk);
    check("t4_r0_ready", {63'd0, r0_req_ready}, 64'd1);
    step();
    r0_req_valid = 1'b0; flush = 1'b1;
    r1_req_valid = 1'b1; r1_req_op1 = 32'd1; r1_req_op2 = 32'd2; r1_req_op = 7'h01;
    @(negedge clk);
    check("t4_no_ready_in_flush", {63'd0, r1_req_ready}, 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t4_no_rsp_after_flush", {63'd0, r0_rsp_valid}, 64'd0);
    check("t4_accept_after_flush", {63'd0, r1_req_ready}, 64'd1);
    push_exp(1'b1, 32'd3, 1'b0);
    step();
    r1_req_valid = 1'b0;
    repeat (4) step();

    // reset while r1 response is pending
    r1_rsp_ready = 1'b0;
    r1_req_valid = 1'b1; r1_req_op1 = 32'd100; r1_req_op2 = 32'd200; r1_req_op = 7'h01;
    @(negedge clk);
    check("t5_r1_ready", {63'd0, r1_req_ready}, 64'd1);
    step();
    r1_req_valid = 1'b0;
    step();
    @(negedge clk);
    check("t5_rsp_before_rst", {63'd0, r1_rsp_valid}, 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_rsp_valid", {63'd0, r1_rsp_valid}, 64'd0);
    check("t5_rst_res", {32'd0, r1_rsp_res}, 64'd0);
    check("t5_rst_dp_op1", {32'd0, dp_op1}, 64'd0);
    check("t5_rst_dp_op2", {32'd0, dp_op2}, 64'd0);
    check("t5_rst_dp_op", {57'd0, dp_op}, 64'd0);
    step();
    r1_rsp_ready = 1'b1;
    r1_req_valid = 1'b1; r1_req_op1 = 32'd7; r1_req_op2 = 32'd8; r1_req_op = 7'h01;
    @(negedge clk);
    check("t5_post_rst_ready", {63'd0, r1_req_ready}, 64'd1);
    push_exp(1'b1, 32'd15, 1'b0);
    step();
    r1_req_valid = 1'b0;
    step();
    @(negedge clk);
    check("t5_post_rst_latency", {63'd0, r1_rsp_valid}, 64'd1);
    repeat (3) step();

    // starve count was cleared by reset: three r0 grants precede r1 again
    for (int i = 0; i < 4; i++) push_exp(order[i], order[i] ? 32'd4 : 32'd2, 1'b0);
    r0_req_valid = 1'b1; r0_req_op1 = 32'd1; r0_req_op2 = 32'd1; r0_req_op = 7'h01;
    r1_req_valid = 1'b1; r1_req_op1 = 32'd2; r1_req_op2 = 32'd2; r1_req_op = 7'h01;
    grants = 0; guard = 0;
    while (grants < 4 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (r0_req_ready || r1_req_ready) begin
        check("t5_post_rst_owner", {63'd0, r1_req_ready}, {63'd0, order[grants]});
        grants++;
      end
      step();
    end
    check("t5_post_rst_grants", 64'(grants), 64'd4);
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    repeat (4) step();

    // back-to-back beq then bne
    r0_req_valid = 1'b1; r0_req_op1 = 32'd5; r0_req_op2 = 32'd5; r0_req_op = 7'h02;
    @(negedge clk);
    check("t6_beq_ready", {63'd0, r0_req_ready}, 64'd1);
    push_exp(1'b0, 32'd10, 1'b1);
    step();
    r0_req_op = 7'h04;
    @(negedge clk);
    check("t6_exec_no_ready", {63'd0, r0_req_ready}, 64'd0);
    step();
    @(negedge clk);
    check("t6_beq_rsp_valid", {63'd0, r0_rsp_valid}, 64'd1);
    check("t6_bne_ready_on_hs", {63'd0, r0_req_ready}, 64'd1);
    push_exp(1'b0, 32'd10, 1'b0);
    step();
    r0_req_valid = 1'b0;
    @(negedge clk);
    check("t6_bne_exec_op", {57'd0, dp_op}, 64'h04);
    step();
    @(negedge clk);
    check("t6_bne_rsp_valid", {63'd0, r0_rsp_valid}, 64'd1);
    repeat (4) step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
